rd_decode_sb: RTL and testbench
===============================

Name: rd_decode_sb

Overview:
- Write-side partner of the 5-bit register-address selection mux. The mux picks which 5-bit register number (rd, rs1, rs2, r15 for CALL) feeds the register file.
- This block takes the selected destination number and decodes it to a registered one-hot write-enable vector for the 32-entry register file.
- It also keeps a pending-write scoreboard: a register is marked busy from issue until writeback, so the control unit can stall RAW/WAW hazards.
- Sits between the decode/issue stage and the register file write port.

Parameters:
- NREG, 32, number of architectural registers visible to the window; must equal 2**AW.
- AW, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode stage requests to issue an instruction that writes issue_rd.
- issue_rd  in  AW  destination register of the issuing instruction.
- issue_ready  out  1  issue accepted this cycle; combinational.
- rs1  in  AW  source register 1 of the instruction in decode.
- rs2  in  AW  source register 2 of the instruction in decode.
- hazard  out  1  rs1 or rs2 is pending; combinational.
- wb_valid  in  1  writeback stage retires a write.
- wb_rd  in  AW  register being written back.
- wr_en  out  NREG  registered one-hot register-file write enable.
- pending  out  NREG  scoreboard state, bit i = write to register i outstanding.
- pending_cnt  out  AW+1  number of set pending bits, 0..NREG-1.

Behaviour:
- Reset (async, rst_n low): pending=0, pending_cnt=0, wr_en=0. All outputs are forced immediately, whatever the clock is doing. Reset mid-operation discards every outstanding entry.
- Register 0 (%g0):
  - Never marked pending.
  - wr_en[0] is always 0.
  - An issue or wb to r0 is accepted as a no-op.
- issue_ready = !(issue_valid && issue_rd!=0 && pending[issue_rd] && !(wb_valid && wb_rd==issue_rd)).
  - WAW stall unless the same register retires in the same cycle.
- Accepted issue (issue_valid && issue_ready && issue_rd!=0): pending[issue_rd] is set at the next edge.
- Writeback (wb_valid && wb_rd!=0):
  - pending[wb_rd] is cleared at the next edge.
  - wr_en becomes one-hot(wb_rd) for exactly one cycle, starting the cycle after wb_valid. Latency is 1.
  - Otherwise wr_en=0.
- Simultaneous issue and wb to the same register: set wins. pending stays 1 and pending_cnt is unchanged.
- wb to a register not pending: wr_en still pulses and pending stays 0. This is legal for r0-like sinks.
- pending_cnt next value = pending_cnt + set - clear, where set and clear are 1 only when the bit actually changes. It never wraps and saturates logically at NREG-1.
- hazard = (rs1!=0 && pending[rs1]) || (rs2!=0 && pending[rs2]), evaluated on current pending only.
- No internal FSM states beyond the scoreboard vector; the scoreboard per register is IDLE(0) -> BUSY(1) on issue, BUSY -> IDLE on wb.

Optional Feature:
- Macro SB_WB_BYPASS_EN.
- Defined: hazard ignores a source register equal to wb_rd while wb_valid is high in the same cycle. This matches writeback forwarding and removes one stall cycle.
- Undefined: hazard uses pending only, so the stall lasts until the cycle after writeback.

Decomposition:
- Shared package/include holds:
  - the AW and NREG constants;
  - the localparam for register 0 (G0 = 5'd0);
  - the one-hot decode function.
- One natural sub-module: dec5to32, a combinational 5-to-32 one-hot decoder with enable. It is instantiated once for the wb path; the scoreboard set/clear uses the same function.

Test Plan:
- Reset: rst_n=0 asserted mid-cycle with pending=0x0000_0F00 -> pending=0, pending_cnt=0, wr_en=0 immediately, without waiting for a clock edge.
- Issue then wb:
  - issue rd=5 at cycle 0 -> pending=0x20, cnt=1.
  - wb rd=5 at cycle 3 -> wr_en=0x20 in cycle 4 only; pending=0, cnt=0.
- WAW stall: with r7 pending, issue rd=7 -> issue_ready=0 and pending unchanged. Repeat the issue with wb_valid, wb_rd=7 in the same cycle -> issue_ready=1, pending[7] stays 1, cnt unchanged.
- RAW hazard:
  - r9 pending, rs1=9, rs2=3 -> hazard=1.
  - rs1=0, rs2=3 -> hazard=0.
  - With SB_WB_BYPASS_EN: wb_rd=9 that cycle with rs1=9 -> hazard=0.
- %g0: issue rd=0 and wb rd=0 -> issue_ready=1, pending=0, wr_en stays 0.
- Fill: issue r1..r31 on consecutive cycles -> cnt reaches 31, pending=0xFFFF_FFFE. Retire all -> cnt returns to 0.

Source files
------------

// File: rtl/rd_decode_sb_pkg.sv
// Shared constants and helpers for the destination-register decode / scoreboard.
// Optional build macro: SB_WB_BYPASS_EN (used by rd_decode_sb).
package rd_decode_sb_pkg;

    // Register-address width and register count of the window.
    localparam int SB_AW   = 5;
    localparam int SB_NREG = 32;

    // %g0: hard-wired zero register, never tracked and never written.
    localparam logic [SB_AW-1:0] G0 = 5'd0;

    // One-hot decode with enable; all zeros when en is low.
    function automatic logic [SB_NREG-1:0] onehot_dec(input logic [SB_AW-1:0] idx,
                                                      input logic             en);
        logic [SB_NREG-1:0] vec;
        vec = '0;
        if (en) begin
            vec[idx] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/rd_decode_sb_dec5to32.sv
// Combinational 5-to-32 one-hot decoder with enable, used on the writeback path.
module dec5to32
    import rd_decode_sb_pkg::*;
(
    input  logic [SB_AW-1:0]   sel,
    input  logic               en,
    output logic [SB_NREG-1:0] onehot
);

    // Same decode as the scoreboard set path so both sides agree bit-for-bit.
    always_comb begin
        onehot = onehot_dec(sel, en);
    end

endmodule

// File: rtl/rd_decode_sb.sv
// Destination-register write-enable decode plus pending-write scoreboard.
// Optional build macro: SB_WB_BYPASS_EN -- when defined, a source register that
// is being written back this cycle does not raise hazard (writeback forwarding).
//
// Issue handshake: an issue transfers in a cycle where issue_valid && issue_ready
// are both high; issue_ready is combinational and depends on issue_valid, so
// the producer must hold issue_valid/issue_rd stable until the transfer occurs.
// Writeback has no back-pressure: every wb_valid cycle is consumed.
module rd_decode_sb
    import rd_decode_sb_pkg::*;
#(
    // Must stay equal to the package constants (NREG == 2**AW).
    parameter int NREG = SB_NREG,
    parameter int AW   = SB_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            hazard,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    output logic [NREG-1:0] wr_en,
    output logic [NREG-1:0] pending,
    output logic [AW:0]     pending_cnt
);

    logic            wb_hit;
    logic            issue_fire;
    logic            set_chg;
    logic            clr_chg;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] wb_vec;
    logic [NREG-1:0] pending_nxt;
    logic [AW:0]     cnt_nxt;

    // Writes to %g0 are accepted but have no effect anywhere.
    assign wb_hit = wb_valid && (wb_rd != G0);

    dec5to32 u_dec (
        .sel    (wb_rd),
        .en     (wb_hit),
        .onehot (wb_vec)
    );

    // WAW stall: destination still pending unless it retires this very cycle.
    always_comb begin
        issue_ready = !(issue_valid && (issue_rd != G0) && pending[issue_rd] &&
                        !(wb_valid && (wb_rd == issue_rd)));
    end

    // RAW hazard on the current scoreboard, optionally forwarding from writeback.
    always_comb begin
        logic hz1;
        logic hz2;
        hz1 = (rs1 != G0) && pending[rs1];
        hz2 = (rs2 != G0) && pending[rs2];
`ifdef SB_WB_BYPASS_EN
        if (wb_valid && (wb_rd == rs1)) begin
            hz1 = 1'b0;
        end
        if (wb_valid && (wb_rd == rs2)) begin
            hz2 = 1'b0;
        end
`endif
        hazard = hz1 || hz2;
    end

    // Next scoreboard: clear on writeback, then set on issue so set wins a tie.
    // The counter only moves when a bit really flips.
    always_comb begin
        issue_fire  = issue_valid && issue_ready && (issue_rd != G0);
        set_vec     = onehot_dec(issue_rd, issue_fire);
        pending_nxt = (pending & ~wb_vec) | set_vec;
        set_chg     = issue_fire && !pending[issue_rd];
        clr_chg     = wb_hit && pending[wb_rd] && !(issue_fire && (issue_rd == wb_rd));
        cnt_nxt     = pending_cnt + (AW+1)'(set_chg) - (AW+1)'(clr_chg);
    end

    // Scoreboard, counter and one-cycle write-enable pulse; reset drops everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            pending_cnt <= '0;
            wr_en       <= '0;
        end else begin
            pending     <= pending_nxt;
            pending_cnt <= cnt_nxt;
            wr_en       <= wb_vec;
        end
    end

endmodule

// File: tb/tb_rd_decode_sb.sv
// Directed + random bench for rd_decode_sb with a wr_en expected queue and a
// popcount-based scoreboard model.
module tb_rd_decode_sb;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hazard;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wr_en;
    logic [31:0] pending;
    logic [5:0]  pending_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_pending;

    rd_decode_sb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .hazard      (hazard),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wr_en       (wr_en),
        .pending     (pending),
        .pending_cnt (pending_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus. Entered at posedge+1; combinational outputs are
    // checked mid-cycle, registered outputs at the following posedge+1.
    task automatic cycle(input logic iv, input logic [4:0] ird,
                         input logic wv, input logic [4:0] wrd,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input string tag);
        logic        e_ready;
        logic        e_hz1;
        logic        e_hz2;
        logic [31:0] e_wr;
        logic [31:0] got_exp;
        issue_valid = iv;
        issue_rd    = ird;
        wb_valid    = wv;
        wb_rd       = wrd;
        rs1         = r1;
        rs2         = r2;
        #2;
        e_ready = !(iv && ird != 5'd0 && m_pending[ird] && !(wv && wrd == ird));
        e_hz1   = (r1 != 5'd0) && m_pending[r1];
        e_hz2   = (r2 != 5'd0) && m_pending[r2];
`ifdef SB_WB_BYPASS_EN
        if (wv && wrd == r1) e_hz1 = 1'b0;
        if (wv && wrd == r2) e_hz2 = 1'b0;
`endif
        chk({tag, ".ready"}, issue_ready, e_ready);
        chk({tag, ".hazard"}, hazard, e_hz1 || e_hz2);
        e_wr = '0;
        if (wv && wrd != 5'd0) begin
            e_wr[wrd] = 1'b1;
            m_pending[wrd] = 1'b0;
        end
        if (iv && e_ready && ird != 5'd0) m_pending[ird] = 1'b1;
        exp_q.push_back(e_wr);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, ".q_empty"}, 1'b1, 1'b0);
        end else begin
            got_exp = exp_q.pop_front();
            chk({tag, ".wr_en"}, wr_en, got_exp);
        end
        chk({tag, ".pending"}, pending, m_pending);
        chk({tag, ".cnt"}, pending_cnt, $countones(m_pending));
    endtask

    task automatic idle(input string tag);
        cycle(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        issue_valid = 1'b0; issue_rd = '0; wb_valid = 1'b0; wb_rd = '0; rs1 = '0; rs2 = '0;
        m_pending = '0;

        // Reset state before any clock edge
        #2;
        chk("rst.pending", pending, 32'h0);
        chk("rst.cnt", pending_cnt, 6'd0);
        chk("rst.wr_en", wr_en, 32'h0);
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Issue r5, writeback three cycles later
        cycle(1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0, "iss5");
        chk("iss5.pending_c", pending, 32'h20);
        chk("iss5.cnt_c", pending_cnt, 6'd1);
        idle("gap1");
        idle("gap2");
        cycle(1'b0, 5'd0, 1'b1, 5'd5, 5'd0, 5'd0, "wb5");
        chk("wb5.wr_en_c", wr_en, 32'h20);
        chk("wb5.pending_c", pending, 32'h0);
        idle("wb5_after");
        chk("wb5.wr_en_off", wr_en, 32'h0);

        // WAW stall and same-cycle retire
        cycle(1'b1, 5'd7, 1'b0, 5'd0, 5'd0, 5'd0, "iss7");
        issue_valid = 1'b1; issue_rd = 5'd7; #2;
        chk("waw.stall", issue_ready, 1'b0);
        cycle(1'b1, 5'd7, 1'b0, 5'd0, 5'd0, 5'd0, "waw");
        cycle(1'b1, 5'd7, 1'b1, 5'd7, 5'd0, 5'd0, "waw_wb");
        chk("waw_wb.bit7", pending[7], 1'b1);
        chk("waw_wb.cnt_c", pending_cnt, 6'd1);
        cycle(1'b0, 5'd0, 1'b1, 5'd7, 5'd0, 5'd0, "wb7");

        // RAW hazard
        cycle(1'b1, 5'd9, 1'b0, 5'd0, 5'd0, 5'd0, "iss9");
        cycle(1'b0, 5'd0, 1'b0, 5'd0, 5'd9, 5'd3, "raw_9_3");
        rs1 = 5'd9; rs2 = 5'd3; #2;
        chk("raw.hz_c", hazard, 1'b1);
        cycle(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd3, "raw_0_3");
        cycle(1'b0, 5'd0, 1'b1, 5'd9, 5'd9, 5'd3, "raw_byp");

        // %g0 no-op and writeback of a non-pending register
        cycle(1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, "g0");
        idle("g0_after");
        cycle(1'b0, 5'd0, 1'b1, 5'd20, 5'd0, 5'd0, "wb_np");

        // Fill r1..r31 then retire all
        for (int i = 1; i < 32; i++) begin
            cycle(1'b1, 5'(i), 1'b0, 5'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "fill");
        end
        chk("fill.cnt_c", pending_cnt, 6'd31);
        chk("fill.pending_c", pending, 32'hFFFF_FFFE);
        for (int i = 1; i < 32; i++) begin
            cycle(1'b0, 5'd0, 1'b1, 5'(i), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "drain");
        end
        idle("drain_end");
        chk("drain.cnt_c", pending_cnt, 6'd0);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rand");
        end
        for (int i = 1; i < 32; i++) begin
            cycle(1'b0, 5'd0, 1'b1, 5'(i), 5'd0, 5'd0, "clean");
        end

        // Asynchronous reset mid-cycle with r8..r11 pending and wr_en active
        for (int i = 8; i < 12; i++) begin
            cycle(1'b1, 5'(i), 1'b0, 5'd0, 5'd0, 5'd0, "pre_rst");
        end
        cycle(1'b0, 5'd0, 1'b1, 5'd12, 5'd0, 5'd0, "pre_rst_wb");
        chk("pre_rst.pending", pending, 32'h0000_0F00);
        chk("pre_rst.wr_en", wr_en, 32'h0000_1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.pending", pending, 32'h0);
        chk("arst.cnt", pending_cnt, 6'd0);
        chk("arst.wr_en", wr_en, 32'h0);
        m_pending = '0;
        exp_q.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle("post_rst");
        cycle(1'b1, 5'd3, 1'b0, 5'd0, 5'd0, 5'd0, "post_iss3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
